vid_axis_tx_ch: RTL

Per-channel converter from the parallel video domain (sof/valid/data strobes) back to an AXI4-Stream video master. It retimes each frame into AXIS video framing: tuser on the first pixel of a frame, tlast on the last pixel of each line. An internal FIFO absorbs downstream backpressure. Sticky overflow and frame/line status are reported for the register block.

---
 rtl/vid_axis_tx_ch.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/vid_axis_tx_ch.sv
// Per-channel parallel-video to AXI4-Stream video master.
// Tags pixels with tuser/tlast, buffers them in a FIFO, and drives a single
// registered AXIS slice. The output slice counts as one of the 2^AW storage
// slots, so fifo_lvl covers every pixel held inside the block.
module vid_axis_tx_ch #(
  parameter int          AW    = 9,
  parameter logic [3:0]  TDEST = 4'h0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vrst_n,
  input  logic [15:0]   col_len,
  input  logic          sof_i,
  input  logic          vin,
  input  logic [15:0]   din,
  output logic          tvalid,
  input  logic          tready,
  output logic          tuser,
  output logic          tlast,
  output logic [15:0]   tdata,
  output logic [3:0]    tdest,
  output logic [AW:0]   fifo_lvl,
  output logic          ovf,
  output logic [15:0]   drop_cnt,
  output logic [31:0]   frm_cnt,
  output logic [15:0]   line_cnt
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  logic [17:0] mem_q [DEPTH];

  logic [AW:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [15:0]  col_q, col_d;
  logic         pend_user_q, pend_user_d;
  logic [15:0]  line_cnt_q, line_cnt_d;
  logic [31:0]  frm_cnt_q, frm_cnt_d;
  logic         ovf_q, ovf_d;
  logic [15:0]  drop_cnt_q, drop_cnt_d;
  logic         tvalid_q, tvalid_d;
  logic         tuser_q, tuser_d;
  logic         tlast_q, tlast_d;
  logic [15:0]  tdata_q, tdata_d;

  logic [AW:0]  mem_cnt;
  logic [AW:0]  lvl;
  logic         full, mem_empty, hs, load, push, drop;
  logic         v_en, s_en;
  logic [15:0]  col_base;
  logic         tlast_w, tuser_w;
  logic [17:0]  rd_word;

  assign mem_cnt   = wr_ptr_q - rd_ptr_q;
  assign lvl       = mem_cnt + {{AW{1'b0}}, tvalid_q};
  assign full      = (lvl == DEPTH_L);
  assign mem_empty = (mem_cnt == '0);
  assign hs        = tvalid_q & tready;
  assign load      = ~mem_empty & (~tvalid_q | tready);
  assign v_en      = vin & vrst_n;
  assign s_en      = sof_i & vrst_n;
  // A handshake on the output frees a slot in the same cycle, so a pixel
  // arriving at full alongside a handshake is still accepted.
  assign push      = v_en & (~full | hs);
  assign drop      = v_en & full & ~hs;
  assign rd_word   = mem_q[rd_ptr_q[AW-1:0]];

  // Pixel tagging: a coincident sof_i makes this pixel column 0 of a new frame.
  always_comb begin
    col_base = s_en ? 16'd0 : col_q;
    tlast_w  = (col_len != 16'd0) && (col_base == col_len - 16'd1);
    tuser_w  = pend_user_q | s_en;
  end

  // Next-state logic for tagging, counters, FIFO pointers and the output slice.
  always_comb begin
    col_d       = col_q;
    pend_user_d = pend_user_q;
    line_cnt_d  = line_cnt_q;
    frm_cnt_d   = frm_cnt_q;
    ovf_d       = ovf_q | drop;
    drop_cnt_d  = drop_cnt_q;
    wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, load};
    tvalid_d    = tvalid_q;
    tuser_d     = tuser_q;
    tlast_d     = tlast_q;
    tdata_d     = tdata_q;

    if (s_en) begin
      col_d       = 16'd0;
      pend_user_d = 1'b1;
      line_cnt_d  = 16'd0;
      frm_cnt_d   = frm_cnt_q + 32'd1;
    end
    if (v_en) begin
      col_d       = tlast_w ? 16'd0 : col_base + 16'd1;
      pend_user_d = 1'b0;
      if (tlast_w && !s_en) line_cnt_d = line_cnt_q + 16'd1;
    end
    if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;

    // Slice payload only changes on a load, so it stays stable while stalled.
    if (load) begin
      tvalid_d = 1'b1;
      tuser_d  = rd_word[17];
      tlast_d  = rd_word[16];
      tdata_d  = rd_word[15:0];
    end else if (tready) begin
      tvalid_d = 1'b0;
    end

    if (!vrst_n) begin
      col_d       = 16'd0;
      pend_user_d = 1'b0;
      line_cnt_d  = 16'd0;
      frm_cnt_d   = 32'd0;
      ovf_d       = 1'b0;
      drop_cnt_d  = 16'd0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      tvalid_d    = 1'b0;
      tuser_d     = 1'b0;
      tlast_d     = 1'b0;
      tdata_d     = 16'd0;
    end
  end

  // Pixel storage; contents need no reset because the pointers gate reads.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {tuser_w, tlast_w, din};
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      col_q       <= 16'd0;
      pend_user_q <= 1'b0;
      line_cnt_q  <= 16'd0;
      frm_cnt_q   <= 32'd0;
      ovf_q       <= 1'b0;
      drop_cnt_q  <= 16'd0;
      tvalid_q    <= 1'b0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
      tdata_q     <= 16'd0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      col_q       <= col_d;
      pend_user_q <= pend_user_d;
      line_cnt_q  <= line_cnt_d;
      frm_cnt_q   <= frm_cnt_d;
      ovf_q       <= ovf_d;
      drop_cnt_q  <= drop_cnt_d;
      tvalid_q    <= tvalid_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
      tdata_q     <= tdata_d;
    end
  end

  assign tvalid   = tvalid_q;
  assign tuser    = tuser_q;
  assign tlast    = tlast_q;
  assign tdata    = tdata_q;
  assign tdest    = TDEST;
  assign fifo_lvl = lvl;
  assign ovf      = ovf_q;
  assign drop_cnt = drop_cnt_q;
  assign frm_cnt  = frm_cnt_q;
  assign line_cnt = line_cnt_q;

endmodule
